// File: rtl/trace_pkg.sv
// Shared types for the RVFI trace capture block.
//   trace_mode_e  : capture mode encoding driven on mode_i.
//   trace_entry_t : one captured retirement, oldest field (seq) in the MSBs.
// Optional: define TRACE_MEM_EN to add the memory address/mask fields to
// every entry.
package trace_pkg;

  localparam int TRACE_DEPTH = 16;
  localparam int TRACE_SEQ_W = 16;

  typedef enum logic [1:0] {
    TRACE_OFF   = 2'd0,
    TRACE_ALL   = 2'd1,
    TRACE_EXC   = 2'd2,
    TRACE_PCWIN = 2'd3
  } trace_mode_e;

  typedef struct packed {
    logic [TRACE_SEQ_W-1:0] seq;
    logic [31:0]            pc;
    logic [31:0]            insn;
    logic [4:0]             rd_addr;
    logic [31:0]            rd_wdata;
    logic                   trap;
    logic                   intr;
`ifdef TRACE_MEM_EN
    logic [31:0]            mem_addr;
    logic [3:0]             mem_rmask;
    logic [3:0]             mem_wmask;
`endif
  } trace_entry_t;

endpackage

// File: rtl/trace_ring_buf.sv
// Circular entry store with registered occupancy.
//   clk/rst_n : clock, synchronous active-low reset
//   clr       : flush (wins over push/pop)
//   push/wdata: write request; pop: consume head (ignored when empty)
//   rdata     : entry at the read pointer
//   count/full/empty : occupancy status
//   lost      : a push found the buffer full with no pop this cycle
//               (dropped, or overwrote the oldest when Overwrite=1)
module trace_ring_buf #(
  parameter int Depth     = 16,
  parameter int W         = 8,
  parameter bit Overwrite = 1'b0,
  localparam int PtrW     = $clog2(Depth),
  localparam int CntW     = PtrW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            push,
  input  logic [W-1:0]    wdata,
  input  logic            pop,
  output logic [W-1:0]    rdata,
  output logic [CntW-1:0] count,
  output logic            full,
  output logic            empty,
  output logic            lost
);

  logic [W-1:0]    mem [Depth];
  logic [PtrW-1:0] wr_ptr, rd_ptr;
  logic [CntW-1:0] cnt, cnt_nxt;
  logic            do_pop, wr_en, rd_adv;

  assign full   = (cnt == CntW'(Depth));
  assign empty  = (cnt == '0);
  assign count  = cnt;
  assign rdata  = mem[rd_ptr];
  assign do_pop = pop & ~empty;

  always_comb begin
    wr_en   = 1'b0;
    rd_adv  = do_pop;
    lost    = 1'b0;
    cnt_nxt = cnt;
    if (push && !clr) begin
      if (full && !do_pop) begin
        lost = 1'b1;
        // Overwrite: slot at wr_ptr is the oldest entry, so push it out
        // by advancing the read pointer alongside the write.
        if (Overwrite) begin
          wr_en  = 1'b1;
          rd_adv = 1'b1;
        end
      end else begin
        wr_en = 1'b1;
      end
    end
    if (wr_en && !rd_adv)      cnt_nxt = cnt + CntW'(1);
    else if (!wr_en && rd_adv) cnt_nxt = cnt - CntW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + PtrW'(1);
      if (rd_adv) rd_ptr <= rd_ptr + PtrW'(1);
      cnt <= cnt_nxt;
    end
  end

  // Storage carries no reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/rvfi_trace_buffer.sv
// On-chip trace capture fed by the RVFI retirement port.
// Filters retirements by mode, stamps a sequence number, stores them in a
// ring buffer and exposes a valid/ready readout.
// Ports:
//   CLK, RST_N               : clock, synchronous active-low reset
//   rvfi_*                   : retirement inputs (mem fields only with
//                              TRACE_MEM_EN)
//   mode_i, pc_lo_i, pc_hi_i : capture filter (PC window [lo, hi))
//   freeze_i, clr_i          : suspend capture / flush buffer and counters
//   rd_valid_o/rd_ready_i/rd_entry_o : readout handshake
//   count_o, full_o, empty_o : occupancy; ovf_cnt_o : saturating drop count
// Optional: TRACE_MEM_EN adds mem_addr/mem_rmask/mem_wmask to entries.
module rvfi_trace_buffer
  import trace_pkg::*;
#(
  parameter int Depth     = TRACE_DEPTH,
  parameter int SeqW      = TRACE_SEQ_W,
  parameter int OvfCntW   = 16,
  parameter bit Overwrite = 1'b0
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     rvfi_valid,
  input  logic [31:0]              rvfi_pc_rdata,
  input  logic [31:0]              rvfi_insn,
  input  logic                     rvfi_trap,
  input  logic                     rvfi_intr,
  input  logic [4:0]               rvfi_rd_addr,
  input  logic [31:0]              rvfi_rd_wdata,
  input  logic [31:0]              rvfi_mem_addr,
  input  logic [3:0]               rvfi_mem_rmask,
  input  logic [3:0]               rvfi_mem_wmask,
  input  logic [1:0]               mode_i,
  input  logic [31:0]              pc_lo_i,
  input  logic [31:0]              pc_hi_i,
  input  logic                     freeze_i,
  input  logic                     clr_i,
  output logic                     rd_valid_o,
  input  logic                     rd_ready_i,
  output trace_entry_t             rd_entry_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [OvfCntW-1:0]       ovf_cnt_o
);

  // The entry layout is fixed by the package; the seq width must agree.
  if (SeqW != TRACE_SEQ_W) begin : g_seqw_check
    $error("SeqW must equal trace_pkg::TRACE_SEQ_W");
  end

  trace_mode_e     mode;
  logic            mode_hit, qual, lost, pop;
  logic [SeqW-1:0] seq;
  trace_entry_t    wentry;

  assign mode = trace_mode_e'(mode_i);

  always_comb begin
    mode_hit = 1'b0;
    unique case (mode)
      TRACE_ALL:   mode_hit = 1'b1;
      TRACE_EXC:   mode_hit = rvfi_trap | rvfi_intr;
      // An empty or inverted window matches nothing.
      TRACE_PCWIN: mode_hit = (pc_lo_i < pc_hi_i) &&
                              (rvfi_pc_rdata >= pc_lo_i) &&
                              (rvfi_pc_rdata <  pc_hi_i);
      default:     mode_hit = 1'b0;
    endcase
  end

  assign qual = rvfi_valid & ~freeze_i & mode_hit;
  assign pop  = rd_valid_o & rd_ready_i;

  always_comb begin
    wentry          = '0;
    wentry.seq      = seq;
    wentry.pc       = rvfi_pc_rdata;
    wentry.insn     = rvfi_insn;
    wentry.rd_addr  = rvfi_rd_addr;
    wentry.rd_wdata = rvfi_rd_wdata;
    wentry.trap     = rvfi_trap;
    wentry.intr     = rvfi_intr;
`ifdef TRACE_MEM_EN
    wentry.mem_addr  = rvfi_mem_addr;
    wentry.mem_rmask = rvfi_mem_rmask;
    wentry.mem_wmask = rvfi_mem_wmask;
`endif
  end

`ifndef TRACE_MEM_EN
  logic unused_mem;
  assign unused_mem = ^{rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask};
`endif

  trace_ring_buf #(
    .Depth     (Depth),
    .W         ($bits(trace_entry_t)),
    .Overwrite (Overwrite)
  ) u_ring (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr   (clr_i),
    .push  (qual),
    .wdata (wentry),
    .pop   (pop),
    .rdata (rd_entry_o),
    .count (count_o),
    .full  (full_o),
    .empty (empty_o),
    .lost  (lost)
  );

  assign rd_valid_o = ~empty_o;

  // seq advances on every qualified retire, dropped ones included, so a
  // consumer can spot losses as gaps.
  always_ff @(posedge CLK) begin
    if (!RST_N || clr_i) begin
      seq       <= '0;
      ovf_cnt_o <= '0;
    end else begin
      if (qual) seq <= seq + SeqW'(1);
      if (lost && (ovf_cnt_o != '1)) ovf_cnt_o <= ovf_cnt_o + OvfCntW'(1);
    end
  end

endmodule

// File: doc/rvfi_trace_buffer.md
Name: rvfi_trace_buffer

Overview:
Parametrised on-chip trace capture block fed by the core's RVFI retirement port, alongside or instead of the simulation-only tracer.
- Filters retired instructions by mode.
- Stores them in a circular buffer of Depth entries, tagged with a sequence number.
- Exposes a valid/ready readout port for a debug or streaming unit.
- Adds what the tracer lacks: selectable filtering, bounded storage with an overflow policy, drop counting, and backpressured readout.

Parameters:
- Depth, 16, number of entries; power of two, >= 2.
- SeqW, 16, width of the per-entry sequence number.
- OvfCntW, 16, width of the saturating drop counter.
- Overwrite, 1'b0, overflow policy: 0 = drop new entries when full, 1 = overwrite the oldest entry.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  reset; synchronous, active-low.
- rvfi_valid  in  1  instruction retired this cycle.
- rvfi_pc_rdata  in  32  retiring PC.
- rvfi_insn  in  32  instruction word.
- rvfi_trap  in  1  instruction trapped.
- rvfi_intr  in  1  first instruction of a handler.
- rvfi_rd_addr  in  5  destination register.
- rvfi_rd_wdata  in  32  destination write data.
- rvfi_mem_addr  in  32  memory address (used only with TRACE_MEM_EN).
- rvfi_mem_rmask  in  4  read mask (used only with TRACE_MEM_EN).
- rvfi_mem_wmask  in  4  write mask (used only with TRACE_MEM_EN).
- mode_i  in  2  capture mode: 0 OFF, 1 ALL, 2 EXC (trap|intr only), 3 PCWIN.
- pc_lo_i  in  32  PC window lower bound, inclusive.
- pc_hi_i  in  32  PC window upper bound, exclusive.
- freeze_i  in  1  suspend capture.
- clr_i  in  1  flush the buffer and clear the counters.
- rd_valid_o  out  1  entry available.
- rd_ready_i  in  1  consumer accepts the entry.
- rd_entry_o  out  $bits(trace_entry_t)  entry at the read pointer.
- count_o  out  $clog2(Depth)+1  current occupancy.
- full_o  out  1  count_o == Depth.
- empty_o  out  1  count_o == 0.
- ovf_cnt_o  out  OvfCntW  entries lost, saturating.

Behaviour:
- Reset (RST_N low at a CLK edge) and clr_i both:
  - set the pointers to 0, count_o = 0, empty_o = 1, full_o = 0, rd_valid_o = 0;
  - set ovf_cnt_o = 0 and the sequence counter to 0;
  - leave storage contents undefined.
- Reset mid-operation discards all entries. clr_i takes priority over a simultaneous push and pop.
- Qualify (combinational): qual = rvfi_valid & ~freeze_i & mode match.
  - ALL: always matches.
  - EXC: matches when rvfi_trap | rvfi_intr.
  - PCWIN: matches when pc_lo_i <= rvfi_pc_rdata < pc_hi_i (unsigned). If pc_lo_i >= pc_hi_i, nothing matches.
  - OFF: never matches.
- Mode, freeze and bound changes apply to the same cycle's rvfi_valid. There is no latching.
- Push: when qual is set, the entry is written at the clock edge:
  - entry = {seq, pc, insn, rd_addr, rd_wdata, trap, intr};
  - seq = current sequence counter, which then increments mod 2^SeqW.
  - The entry is visible on rd_entry_o and rd_valid_o the cycle after the write. Latency is 1 cycle; there is no bypass.
- Pop: occurs when rd_valid_o & rd_ready_i.
  - rd_valid_o = ~empty_o.
  - rd_entry_o = storage at the read pointer; it is held stable while rd_valid_o & ~rd_ready_i.
- Push and pop in the same cycle while not full: both happen and count_o is unchanged.
- Full, push and pop in the same cycle: both happen, nothing is lost, in either policy.
- Full, push, no pop, Overwrite = 0:
  - the push is dropped and ovf_cnt_o increments;
  - the sequence counter still increments, so the consumer sees a gap.
- Full, push, no pop, Overwrite = 1:
  - the new entry replaces the oldest and both pointers advance;
  - count_o stays at Depth and ovf_cnt_o increments.
- ovf_cnt_o saturates at all-ones.
- Pointers wrap modulo Depth. count_o is the registered occupancy, not a pointer difference.

Optional Feature:
Macro TRACE_MEM_EN.
- Defined: trace_entry_t adds mem_addr (32), mem_rmask (4) and mem_wmask (4), captured from RVFI.
- Not defined: those fields are absent and the three mem inputs are ignored (kept as unused signals).
- Port list and all other behaviour are identical in both builds.

Decomposition:
- Package trace_pkg holds:
  - trace_mode_e {TRACE_OFF, TRACE_ALL, TRACE_EXC, TRACE_PCWIN};
  - trace_entry_t, a packed struct parameterised via SeqW and with TRACE_MEM_EN-conditional fields;
  - the localparam for the default depth.
- One sub-module, trace_ring_buf: circular storage with pointers, count, full/empty and the overwrite/drop decision.
- The top block holds the qualify logic, the sequence counter and ovf_cnt_o.

Test Plan:
- Mode ALL, Depth 16, rd_ready_i = 1, retire 5 instructions at PC 0x100..0x110 → 5 entries popped in order, seq 0..4, each one cycle after retire, count_o returns to 0.
- Mode PCWIN with pc_lo_i = 0x200, pc_hi_i = 0x300, retire PCs 0x1FC, 0x200, 0x2FC, 0x300 → only 0x200 and 0x2FC captured, with seq 0 and 1. Then set pc_lo_i = pc_hi_i = 0x200 → nothing captured.
- Overwrite = 0, rd_ready_i = 0, 20 qualifying retires → full_o = 1, count_o = 16, ovf_cnt_o = 4; draining yields seq 0..15; the next capture has seq 20.
- Overwrite = 1, same stimulus → count_o = 16, ovf_cnt_o = 4; draining yields seq 4..19.
- Full buffer with simultaneous push and pop → count_o stays 16, ovf_cnt_o unchanged. Then assert clr_i together with a push → count_o = 0, ovf_cnt_o = 0, next seq = 0.
- Mode EXC plus freeze_i: trap retire with freeze_i = 1 → not captured and not counted. Trap retire with freeze_i = 0 → captured with trap = 1. A plain retire → not captured. Assert RST_N low mid-drain → rd_valid_o = 0 on the next cycle.
